// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: opcodes, FSM state
// encodings and the default memory-wait budget.
package cpu_pkg;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ADD   = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_AND   = 4'h3;
   localparam logic [3:0] OP_OR    = 4'h4;
   localparam logic [3:0] OP_LOAD  = 4'h5;
   localparam logic [3:0] OP_STORE = 4'h6;
   localparam logic [3:0] OP_LI    = 4'h7;
   localparam logic [3:0] OP_JUMP  = 4'h8;
   localparam logic [3:0] OP_LT    = 4'h9;
   localparam logic [3:0] OP_NOT   = 4'hA;

   localparam int MEM_TIMEOUT_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_ERROR  = 3'd7
   } state_e;

   // Opcodes above OP_NOT have no datapath action and retire like a NOP.
   function automatic logic is_noop(input logic [3:0] op);
      return (op == OP_NOP) || (op > OP_NOT);
   endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Shared memory port between the sequencer (master) and the memory (slave).
interface cpu_sequencer_if;
   logic mem_req;
   logic mem_we;
   logic mem_sel;
   logic mem_ack;

   modport master (output mem_req, output mem_we, output mem_sel, input mem_ack);
   modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ack);
endinterface

// File: rtl/mem_wait_timer.sv
// Counts memory request cycles that went unanswered; expire flags the last
// cycle a request may still be acknowledged before the bus is declared dead.
module mem_wait_timer
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int TMR_W       = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   // Next count: clear wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + {{(TMR_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == TMR_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Phase sequencer for the 8-bit CPU: steps FETCH/DECODE/EXEC/MEM/WB, turns
// decoder levels into one-cycle strobes and owns the memory req/ack port.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int TMR_W       = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run,
   input  logic                   halt_req,
   input  logic [7:0]             instruction,
   input  logic                   dec_reg_write,
   input  logic                   dec_mem_write,
   input  logic                   dec_mem_to_reg,
   cpu_sequencer_if.master        bus,
   output logic                   ir_load,
   output logic                   pc_inc,
   output logic                   pc_load,
   output logic                   alu_en,
   output logic                   mdr_load,
   output logic                   rf_we,
   output logic                   halted,
   output logic                   err,
   output logic [2:0]             state
);

   state_e     state_q;
   state_e     state_d;
   state_e     boundary;
   logic [3:0] opcode;
   logic       req_state;
   logic       tmr_expire;
   logic       mem_req_c;
   logic       mem_we_c;
   logic       mem_sel_c;
   logic       unused_bits;

   assign opcode    = instruction[7:4];
   assign req_state = (state_q == ST_FETCH) || (state_q == ST_MEM);

   // Operand bits and the writeback mux select belong to the datapath.
   assign unused_bits = ^{instruction[3:0], dec_mem_to_reg};

   // Counter restarts whenever a request phase is left, so every FETCH/MEM
   // entry starts from zero even when MEM retires straight into FETCH.
   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TMR_W       (TMR_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (!req_state || bus.mem_ack),
      .en     (req_state && !bus.mem_ack),
      .expire (tmr_expire)
   );

   // Where an instruction goes when it retires.
   always_comb begin
      if (halt_req) begin
         boundary = ST_HALT;
      end else if (!run) begin
         boundary = ST_IDLE;
      end else begin
         boundary = ST_FETCH;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      state_d   = state_q;
      mem_req_c = 1'b0;
      mem_we_c  = 1'b0;
      mem_sel_c = 1'b0;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      alu_en    = 1'b0;
      mdr_load  = 1'b0;
      rf_we     = 1'b0;
      halted    = 1'b0;
      err       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            mem_req_c = 1'b1;
            if (bus.mem_ack) begin
               ir_load = 1'b1;
               pc_inc  = 1'b1;
               state_d = ST_DECODE;
            end else if (tmr_expire) begin
               state_d = ST_ERROR;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (is_noop(opcode)) begin
               state_d = boundary;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_en = (opcode != OP_JUMP);
            if (opcode == OP_JUMP) begin
               pc_load = 1'b1;
               state_d = boundary;
            end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            mem_req_c = 1'b1;
            mem_sel_c = 1'b1;
            mem_we_c  = dec_mem_write;
            if (bus.mem_ack) begin
               if (opcode == OP_LOAD) begin
                  mdr_load = 1'b1;
                  state_d  = ST_WB;
               end else begin
                  state_d  = boundary;
               end
            end else if (tmr_expire) begin
               state_d = ST_ERROR;
            end else begin
               state_d = ST_MEM;
            end
         end
         ST_WB: begin
            rf_we   = dec_reg_write;
            state_d = boundary;
         end
         ST_HALT: begin
            halted = 1'b1;
            if (!halt_req && !run) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_HALT;
            end
         end
         ST_ERROR: begin
            err     = 1'b1;
            state_d = ST_ERROR;
         end
         default: begin
            state_d = ST_ERROR;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign bus.mem_req = mem_req_c;
   assign bus.mem_we  = mem_we_c;
   assign bus.mem_sel = mem_sel_c;
   assign state       = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with hand-computed per-cycle state and
// strobe expectations; timeout shortened to 4 request cycles.
module tb_cpu_sequencer;
   import cpu_pkg::*;

   // Strobe vector bit order: req we sel ir pc_inc pc_load alu mdr rf_we halted err
   localparam logic [10:0] O_NONE  = 11'b000_0000_0000;
   localparam logic [10:0] O_F     = 11'b100_0000_0000;
   localparam logic [10:0] O_F_ACK = 11'b100_1100_0000;
   localparam logic [10:0] O_ALU   = 11'b000_0001_0000;
   localparam logic [10:0] O_PCL   = 11'b000_0010_0000;
   localparam logic [10:0] O_RFW   = 11'b000_0000_0100;
   localparam logic [10:0] O_MEMR  = 11'b101_0000_0000;
   localparam logic [10:0] O_LDACK = 11'b101_0000_1000;
   localparam logic [10:0] O_ST    = 11'b111_0000_0000;
   localparam logic [10:0] O_HALT  = 11'b000_0000_0010;
   localparam logic [10:0] O_ERR   = 11'b000_0000_0001;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       halt_req;
   logic [7:0] instruction;
   logic       dec_reg_write;
   logic       dec_mem_write;
   logic       dec_mem_to_reg;
   logic       ir_load, pc_inc, pc_load, alu_en, mdr_load, rf_we, halted, err;
   logic [2:0] state;
   logic [10:0] outs;
   int         n_checks = 0;
   int         n_fail   = 0;

   cpu_sequencer_if bus ();

   cpu_sequencer #(.MEM_TIMEOUT(4), .TMR_W(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .run            (run),
      .halt_req       (halt_req),
      .instruction    (instruction),
      .dec_reg_write  (dec_reg_write),
      .dec_mem_write  (dec_mem_write),
      .dec_mem_to_reg (dec_mem_to_reg),
      .bus            (bus),
      .ir_load        (ir_load),
      .pc_inc         (pc_inc),
      .pc_load        (pc_load),
      .alu_en         (alu_en),
      .mdr_load       (mdr_load),
      .rf_we          (rf_we),
      .halted         (halted),
      .err            (err),
      .state          (state)
   );

   always #5 clk = ~clk;

   assign outs = {bus.mem_req, bus.mem_we, bus.mem_sel, ir_load, pc_inc, pc_load,
                  alu_en, mdr_load, rf_we, halted, err};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive ack, check state and strobes, advance to next cycle.
   task automatic cyc(input string tag, input logic ack, input state_e exp_st,
                      input logic [10:0] exp_o);
      bus.mem_ack = ack;
      #1;
      check_eq({tag, ":st"}, 32'(state), 32'(exp_st));
      check_eq({tag, ":out"}, 32'(outs), 32'(exp_o));
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
   endtask

   task automatic set_instr(input logic [7:0] ins, input logic rw, input logic mw,
                            input logic m2r);
      instruction    = ins;
      dec_reg_write  = rw;
      dec_mem_write  = mw;
      dec_mem_to_reg = m2r;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; halt_req = 1'b0; bus.mem_ack = 1'b0;
      set_instr(8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_eq("reset:st", 32'(state), 32'(ST_IDLE));
      check_eq("reset:out", 32'(outs), 32'(O_NONE));
      rst = 1'b0;

      cyc("idle", 1'b0, ST_IDLE, O_NONE);
      cyc("idle_ack", 1'b1, ST_IDLE, O_NONE);
      run = 1'b1;
      cyc("idle_run", 1'b0, ST_IDLE, O_NONE);

      set_instr(8'h12, 1'b1, 1'b0, 1'b0);
      cyc("add_f", 1'b1, ST_FETCH, O_F_ACK);
      cyc("add_d", 1'b0, ST_DECODE, O_NONE);
      cyc("add_e", 1'b0, ST_EXEC, O_ALU);
      cyc("add_w", 1'b0, ST_WB, O_RFW);

      set_instr(8'h53, 1'b1, 1'b0, 1'b1);
      cyc("ld_f", 1'b1, ST_FETCH, O_F_ACK);
      cyc("ld_d", 1'b0, ST_DECODE, O_NONE);
      cyc("ld_e", 1'b0, ST_EXEC, O_ALU);
      for (int i = 0; i < 3; i++) cyc("ld_mwait", 1'b0, ST_MEM, O_MEMR);
      cyc("ld_mack", 1'b1, ST_MEM, O_LDACK);
      cyc("ld_w", 1'b0, ST_WB, O_RFW);

      set_instr(8'h61, 1'b0, 1'b1, 1'b0);
      cyc("st_f", 1'b1, ST_FETCH, O_F_ACK);
      cyc("st_d", 1'b0, ST_DECODE, O_NONE);
      cyc("st_e", 1'b0, ST_EXEC, O_ALU);
      cyc("st_m", 1'b1, ST_MEM, O_ST);

      set_instr(8'h85, 1'b0, 1'b0, 1'b0);
      cyc("jmp_f", 1'b1, ST_FETCH, O_F_ACK);
      cyc("jmp_d", 1'b0, ST_DECODE, O_NONE);
      cyc("jmp_e", 1'b0, ST_EXEC, O_PCL);

      set_instr(8'h00, 1'b0, 1'b0, 1'b0);
      cyc("nop_f", 1'b1, ST_FETCH, O_F_ACK);
      cyc("nop_d", 1'b0, ST_DECODE, O_NONE);
      set_instr(8'hF0, 1'b0, 1'b0, 1'b0);
      cyc("undef_f", 1'b1, ST_FETCH, O_F_ACK);
      cyc("undef_d", 1'b0, ST_DECODE, O_NONE);

      set_instr(8'h12, 1'b1, 1'b0, 1'b0);
      cyc("h_f", 1'b1, ST_FETCH, O_F_ACK);
      halt_req = 1'b1;
      cyc("h_d", 1'b0, ST_DECODE, O_NONE);
      cyc("h_e", 1'b0, ST_EXEC, O_ALU);
      cyc("h_w", 1'b0, ST_WB, O_RFW);
      cyc("halt1", 1'b0, ST_HALT, O_HALT);
      halt_req = 1'b0;
      cyc("halt_run", 1'b0, ST_HALT, O_HALT);
      run = 1'b0;
      cyc("halt_exit", 1'b0, ST_HALT, O_HALT);
      cyc("halt_idle", 1'b0, ST_IDLE, O_NONE);

      // Asynchronous reset while a fetch request is outstanding.
      run = 1'b1;
      cyc("ar_idle", 1'b0, ST_IDLE, O_NONE);
      #1;
      check_eq("ar_fetch:out", 32'(outs), 32'(O_F));
      #1;
      rst = 1'b1;
      #1;
      check_eq("ar_async:st", 32'(state), 32'(ST_IDLE));
      check_eq("ar_async:out", 32'(outs), 32'(O_NONE));
      run = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc("ar_post", 1'b0, ST_IDLE, O_NONE);

      run = 1'b1;
      cyc("to_idle", 1'b0, ST_IDLE, O_NONE);
      for (int i = 0; i < 4; i++) cyc("to_wait", 1'b0, ST_FETCH, O_F);
      cyc("to_err", 1'b0, ST_ERROR, O_ERR);
      run = 1'b0;
      cyc("to_sticky", 1'b1, ST_ERROR, O_ERR);
      cyc("to_sticky2", 1'b0, ST_ERROR, O_ERR);
      pulse_reset();

      set_instr(8'h00, 1'b0, 1'b0, 1'b0);
      run = 1'b1;
      cyc("late_idle", 1'b0, ST_IDLE, O_NONE);
      for (int i = 0; i < 3; i++) cyc("late_wait", 1'b0, ST_FETCH, O_F);
      cyc("late_ack", 1'b1, ST_FETCH, O_F_ACK);
      run = 1'b0;
      cyc("late_d", 1'b0, ST_DECODE, O_NONE);
      cyc("late_idle2", 1'b0, ST_IDLE, O_NONE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle FSM that sequences the 8-bit CPU datapath through fetch, decode, execute, memory and writeback phases. It gates the combinational decoder's level outputs into one-cycle enables per phase and owns the single shared memory port with a req/ack handshake. It also provides halt handling and a bus-wait timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ack before ERROR (>=2)
TMR_W, 5, timeout counter width; must hold MEM_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  level; leave IDLE and begin fetching while high
halt_req  in  1  level; sampled only at instruction boundary
instruction  in  8  IR contents; opcode = [7:4]
dec_reg_write  in  1  decoder reg_write
dec_mem_write  in  1  decoder mem_write
dec_mem_to_reg  in  1  decoder mem_to_reg
mem_ack  in  1  memory transfer complete, one-cycle pulse
mem_req  out  1  memory request
mem_we  out  1  write strobe, valid with mem_req
mem_sel  out  1  0 = instruction address (PC), 1 = data address (ALU result)
ir_load  out  1  latch mem read data into IR
pc_inc  out  1  PC <= PC+1
pc_load  out  1  PC <= jump target (JUMP only)
alu_en  out  1  latch ALU result register
mdr_load  out  1  latch load data
rf_we  out  1  register-file write enable
halted  out  1  in HALT state
err  out  1  sticky bus timeout flag
state  out  3  current state encoding, for debug

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7.
- Reset (async): state=IDLE, timer=0; all outputs 0. Reset mid-handshake drops mem_req immediately; no pc/rf update occurs.
- All outputs are Moore or state-plus-mem_ack decodes; no registered output delay.
- IDLE: run=1 -> FETCH, else stay.
- FETCH: mem_req=1, mem_sel=0, mem_we=0. On mem_ack: ir_load=1, pc_inc=1 (same cycle) -> DECODE.
- DECODE, one cycle: opcode 0 (NOP) or undefined opcodes 0xB-0xF -> boundary; otherwise -> EXEC.
- EXEC, one cycle: alu_en=1 for every opcode except 8. Opcode 8 (JUMP): pc_load=1 -> boundary. Opcode 5 or 6 -> MEM. Others -> WB.
- MEM: mem_req=1, mem_sel=1, mem_we=dec_mem_write. On mem_ack: LOAD -> mdr_load=1, go WB; STORE -> boundary.
- WB, one cycle: rf_we=dec_reg_write (mux selection is left to dec_mem_to_reg) -> boundary.
- Boundary rule (applies at every instruction end): halt_req=1 -> HALT; else run=0 -> IDLE; else -> FETCH.
- HALT: halted=1; exits to IDLE only when halt_req=0 and run=0.
- Latencies with zero-wait memory (ack in the first request cycle): NOP 2 cycles; JUMP 3; ALU/LI/LT/NOT 4; STORE 4; LOAD 5. Each wait cycle adds 1.
- Timer: clears on entry to FETCH/MEM and increments each request cycle without ack. If the count reaches MEM_TIMEOUT-1 with mem_ack=0 -> ERROR. mem_ack arriving in that same cycle wins, with no error.
- ERROR: err=1 and all strobes 0; left only by rst.
- A mem_ack outside FETCH/MEM is ignored.
- mem_req stays high until the ack cycle inclusive.
- instruction and dec_* must be stable from DECODE through the end of the instruction.

Decomposition:
- Shared package cpu_pkg: opcode localparams (OP_NOP=0 … OP_NOT=4'hA), state encodings, and the default MEM_TIMEOUT.
- Sub-module: mem_wait_timer (clear, enable, expire output) instantiated once.

Test Plan:
- Reset: rst pulse during FETCH with mem_req=1 -> state=0 and all outputs 0 in the same cycle, asynchronously.
- ADD 0x12, zero-wait ack -> states FETCH, DECODE, EXEC, WB; ir_load/pc_inc at cycle 1, alu_en at cycle 3, rf_we at cycle 4; next FETCH at cycle 5.
- LOAD 0x53, ack delayed 3 cycles in MEM -> mdr_load on the ack cycle, rf_we one cycle later; instruction total 8 cycles. STORE 0x61 -> mem_we=1 and mem_sel=1 in MEM, no rf_we.
- JUMP 0x85 -> pc_load=1 in EXEC, pc_inc only in FETCH, no alu_en or rf_we. NOP 0x00 and 0xF0 -> FETCH, DECODE, FETCH.
- halt_req raised mid-instruction -> instruction completes, then HALT with halted=1. Drop halt_req and run -> IDLE.
- MEM_TIMEOUT=4 with no ack -> ERROR after 4 request cycles, err=1 sticky. Repeat with ack in the 4th cycle -> no error.
